// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_sign_conv.sv
// Conditional two's-complement negation: yields the magnitude of an operand
// or applies the sign to an unsigned result, depending on neg_en.
module mult_sign_conv #(
    parameter int W = 8
) (
    input  logic [W-1:0] val,
    input  logic         neg_en,
    output logic [W-1:0] mag
);

    // Negate when requested; the most-negative input maps onto its own bit
    // pattern, which read as unsigned is exactly the required magnitude.
    always_comb begin
        mag = val;
        if (neg_en) begin
            mag = ~val + W'(1);
        end
    end

endmodule

// File: rtl/multiplier_seq_n_bit.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes.
// Signed operands are reduced to magnitudes on acceptance, multiplied
// unsigned over WIDTH cycles, and the sign is applied to the final sum.
module multiplier_seq_n_bit
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     num1,
    input  logic [WIDTH-1:0]     num2,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [PW-1:0]      mcand;
    logic [WIDTH-1:0]   mplier;
    logic [PW-1:0]      acc;
    logic               neg;

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [PW-1:0]      acc_next;
    logic [PW-1:0]      result;
    logic               neg1;
    logic               neg2;

    assign neg1 = signed_mode & num1[WIDTH-1];
    assign neg2 = signed_mode & num2[WIDTH-1];

    mult_sign_conv #(.W(WIDTH)) u_conv_num1 (
        .val    (num1),
        .neg_en (neg1),
        .mag    (mag1)
    );

    mult_sign_conv #(.W(WIDTH)) u_conv_num2 (
        .val    (num2),
        .neg_en (neg2),
        .mag    (mag2)
    );

    // The result conversion sees the sum including the current partial
    // product, so the final CALC edge can load product directly.
    mult_sign_conv #(.W(PW)) u_conv_result (
        .val    (acc_next),
        .neg_en (neg),
        .mag    (result)
    );

    // Accumulate the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // Handshake FSM, iteration counter and shift-add datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            product   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand    <= {{WIDTH{1'b0}}, mag1};
                        mplier   <= mag2;
                        acc      <= '0;
                        cnt      <= '0;
                        neg      <= neg1 ^ neg2;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        product   <= result;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Returning to IDLE here means a new pair can only be
                    // taken on the edge after the transfer.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_seq_n_bit.sv
// Directed bench for multiplier_seq_n_bit (WIDTH=8 and WIDTH=16 instances).
module tb_multiplier_seq_n_bit;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  num1;
    logic [7:0]  num2;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        sm16;
    logic        out_valid16;
    logic        out_ready16;
    logic [31:0] product16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiplier_seq_n_bit #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .num1        (num1),
        .num2        (num2),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product)
    );

    multiplier_seq_n_bit #(.WIDTH(16)) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid16),
        .in_ready    (in_ready16),
        .num1        (a16),
        .num2        (b16),
        .signed_mode (sm16),
        .out_valid   (out_valid16),
        .out_ready   (out_ready16),
        .product     (product16)
    );

    // Present one pair for one edge; the caller knows the DUT is idle.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s);
        num1        = a;
        num2        = b;
        signed_mode = s;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; num1 = '0; num2 = '0; signed_mode = 1'b0; out_ready = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; sm16 = 1'b0; out_ready16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", product); end
        checks++; if (product16 !== 32'h0 || in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
            errors++; $display("FAIL reset_w16: got p=%h rdy=%b vld=%b expected 0/1/0", product16, in_ready16, out_valid16);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned_latency();
        int cyc;
        out_ready = 1'b1;
        start8(8'hA0, 8'h02, 1'b0);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL accept_state: got rdy=%b vld=%b expected 0/0", in_ready, out_valid);
        end
        wait_done8(cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL latency_a0x02: got %0d expected 8", cyc); end
        checks++; if (product !== 16'h0140) begin errors++; $display("FAIL prod_a0x02: got %h expected 0140", product); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL pulse_one_cycle: got vld=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
        start8(8'hFF, 8'h7F, 1'b0);
        wait_done8(cyc);
        checks++; if (product !== 16'h7E81) begin errors++; $display("FAIL prod_u_ffx7f: got %h expected 7e81", product); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        out_ready = 1'b1;
        start8(8'h38, 8'h26, 1'b0);
        wait_done8(cyc);
        checks++; if (product !== 16'h0850) begin errors++; $display("FAIL prod_38x26: got %h expected 0850", product); end
        num1 = 8'hFF; num2 = 8'hFF; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_transfer_edge: got vld=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept_next: got rdy=%b expected 0", in_ready); end
        wait_done8(cyc);
        checks++; if (cyc !== 8 || product !== 16'hFE01) begin
            errors++; $display("FAIL prod_ffxff: got %h after %0d expected fe01 after 8", product, cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        logic [7:0]  ta [4];
        logic [7:0]  tb [4];
        logic [15:0] te [4];
        int cyc;
        ta[0] = 8'h80; tb[0] = 8'h80; te[0] = 16'h4000;
        ta[1] = 8'hFF; tb[1] = 8'h7F; te[1] = 16'hFF81;
        ta[2] = 8'h00; tb[2] = 8'h80; te[2] = 16'h0000;
        ta[3] = 8'h7F; tb[3] = 8'hFE; te[3] = 16'hFF02;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start8(ta[i], tb[i], 1'b1);
            wait_done8(cyc);
            checks++; if (cyc !== 8) begin errors++; $display("FAIL signed_latency_%0d: got %0d expected 8", i, cyc); end
            checks++; if (product !== te[i]) begin
                errors++; $display("FAIL signed_prod_%0d: got %h expected %h", i, product, te[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_operand_change();
        int cyc;
        out_ready = 1'b1;
        start8(8'hF0, 8'h03, 1'b1);
        num1 = 8'h55; num2 = 8'hAA; signed_mode = 1'b0;
        wait_done8(cyc);
        checks++; if (product !== 16'hFFD0) begin errors++; $display("FAIL operand_hold: got %h expected ffd0", product); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        start8(8'h12, 8'h34, 1'b0);
        wait_done8(cyc);
        checks++; if (cyc !== 8 || product !== 16'h03A8) begin
            errors++; $display("FAIL bp_first: got %h after %0d expected 03a8 after 8", product, cyc);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || product !== 16'h03A8 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: got vld=%b p=%h rdy=%b expected 1/03a8/0", i, out_valid, product, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got vld=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++; if (product !== 16'h03A8) begin errors++; $display("FAIL idle_retain: got %h expected 03a8", product); end
    endtask

    task automatic test_reset_abort();
        int cyc;
        logic seen;
        out_ready = 1'b1;
        start8(8'hC3, 8'h5A, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0000) begin
            errors++; $display("FAIL abort_reset_vals: got rdy=%b vld=%b p=%h expected 1/0/0000", in_ready, out_valid, product);
        end
        #1;
        rst_n = 1'b1;
        start8(8'h03, 8'h05, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL first_edge_accept: got rdy=%b expected 0", in_ready); end
        wait_done8(cyc);
        checks++; if (cyc !== 8 || product !== 16'h000F) begin
            errors++; $display("FAIL abort_next_op: got %h after %0d expected 000f after 8", product, cyc);
        end
        @(posedge clk); #1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stray_out_valid: got %b expected 0", seen); end
    endtask

    task automatic test_width16();
        int cyc;
        out_ready16 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; sm16 = 1'b0; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        checks++; if (in_ready16 !== 1'b0) begin errors++; $display("FAIL w16_accept: got %b expected 0", in_ready16); end
        cyc = 0;
        while (!out_valid16 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== 16) begin errors++; $display("FAIL w16_latency: got %0d expected 16", cyc); end
        checks++; if (product16 !== 32'hFFFE0001) begin errors++; $display("FAIL w16_prod: got %h expected fffe0001", product16); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_unsigned_latency();
        test_back_to_back();
        test_signed();
        test_operand_change();
        test_backpressure();
        test_reset_abort();
        test_width16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multiplier_seq_n_bit.md
MULTIPLIER_SEQ_N_BIT -- requirements
Module: multiplier_seq_n_bit

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operand pair and mode are presented.
REQ-005 Port: in_ready  output  1  block can accept an operand pair.
REQ-006 Port: num1  input  WIDTH  multiplicand.
REQ-007 Port: num2  input  WIDTH  multiplier.
REQ-008 Port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
REQ-009 Port: out_valid  output  1  product is valid.
REQ-010 Port: out_ready  input  1  consumer accepts the product.
REQ-011 Port: product  output  2*WIDTH  result; full width, never truncated.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 IDLE SHALL drive in_ready=1 and out_valid=0; in_ready SHALL be 0 in CALC and DONE.
REQ-014 Acceptance SHALL occur on an edge with in_valid&&in_ready; num1, num2 and signed_mode SHALL be registered there, and the state SHALL go IDLE->CALC.
REQ-015 Operand changes after acceptance SHALL have no effect on the result in flight.
REQ-016 CALC SHALL perform radix-2 shift-add, one multiplier bit per cycle (LSB first), for exactly WIDTH cycles, counted by a counter of width clog2(WIDTH+1).
REQ-017 out_valid SHALL rise on the WIDTH-th rising edge after the accepting edge (state CALC->DONE); latency from acceptance to out_valid is WIDTH cycles.
REQ-018 Unsigned mode: product SHALL equal num1*num2 as unsigned 2*WIDTH-bit values.
REQ-019 Signed mode: the operation SHALL use operand magnitudes and negate the result when the operand signs differ; product SHALL be the exact 2*WIDTH-bit two's-complement product.
REQ-020 Signed mode, both operands at most negative: the result SHALL be exact (WIDTH=8: -128*-128 = 16'h4000).
REQ-021 A zero operand SHALL still take the full WIDTH cycles; there is no early termination.
REQ-022 In DONE, product and out_valid SHALL hold stable while out_ready=0, for any number of cycles.
REQ-023 In DONE, out_valid&&out_ready on an edge SHALL complete the transfer: state DONE->IDLE, and out_valid falls on that edge.
REQ-024 A new operand pair SHALL NOT be accepted on the same edge as the product transfer; the earliest acceptance is the following edge.
REQ-025 product SHALL retain the last result in IDLE until the next DONE updates it.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, in_ready=1, out_valid=0, product=0, counter=0, internal accumulators=0.
REQ-027 Reset asserted during CALC or DONE SHALL abort the operation; no out_valid pulse for it SHALL appear after reset release.
REQ-028 After rst_n rises, the first acceptance SHALL be possible on the first rising edge.

Structure
REQ-029 A shared package mult_pkg SHALL hold the FSM state typedef (IDLE/CALC/DONE) and the default WIDTH constant.
REQ-030 The magnitude/negation logic SHALL be a single sub-module, mult_sign_conv, used for the operand-magnitude conversion and for the result-negation step.
REQ-031 The FSM, counter and shift-add datapath SHALL reside in multiplier_seq_n_bit.

Verification
REQ-032 WIDTH=8, unsigned, num1=8'hA0, num2=8'h02, out_ready=1 -> product=16'h0140; out_valid exactly 8 cycles after acceptance, high for 1 cycle.
REQ-033 WIDTH=8, unsigned, num1=8'h38, num2=8'h26, then num1=num2=8'hFF back-to-back -> product=16'h0850, then 16'hFE01; second acceptance 1 cycle after the first transfer.
REQ-034 WIDTH=8, signed: num1=8'h80, num2=8'h80 -> 16'h4000; num1=8'hFF, num2=8'h7F -> 16'hFF81; num1=8'h00, num2=8'h80 -> 16'h0000.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and product stable, in_ready=0; out_ready=1 -> transfer, IDLE next.
REQ-036 Reset pulse in the 4th CALC cycle -> all outputs at reset values immediately; no out_valid afterwards; next operation 8'h03*8'h05 -> 16'h000F.
REQ-037 WIDTH=16 instance, unsigned, 16'hFFFF*16'hFFFF -> 32'hFFFE0001 after 16 cycles.
